// File: rtl/instr_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pkg
//  Description : Shared opcode constants, ALU-operation encoding, decoded
//                control bundle and field-position helper for the 28-bit
//                processor decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

   // Defined opcodes; every other opcode value decodes as illegal
   localparam int unsigned OP_ADD   = 0;
   localparam int unsigned OP_ADDU  = 1;
   localparam int unsigned OP_STORE = 2;
   localparam int unsigned OP_LOAD  = 3;
   localparam int unsigned OP_LOADI = 4;
   localparam int unsigned OP_BEQ   = 5;
   localparam int unsigned OP_SLT   = 6;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_ADDU  = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_SLT   = 3'd3,
      ALU_PASSB = 3'd4
   } alu_op_e;

   // Datapath control signals carried alongside each decoded instruction
   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src_imm;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    uses_rs;
      logic    uses_rt;
      logic    illegal;
   } ctrl_t;

   // Field identifiers, listed from least to most significant position
   localparam int FLD_IMM = 0;
   localparam int FLD_RD  = 1;
   localparam int FLD_RT  = 2;
   localparam int FLD_RS  = 3;
   localparam int FLD_OP  = 4;

   // LSB position of a field: imm sits at bit 0, then Rd, Rt, Rs, opcode
   function automatic int field_lsb(input int fld, input int reg_w, input int imm_w);
      return (fld == FLD_IMM) ? 0 : imm_w + (fld - 1) * reg_w;
   endfunction

   // Control decode of one opcode; unknown opcodes flag illegal with no side effects
   function automatic ctrl_t decode_ctrl(input logic [31:0] op);
      ctrl_t c;
      c             = '0;
      c.alu_op      = ALU_PASSB;
      c.illegal     = 1'b1;
      case (op)
         OP_ADD, OP_ADDU: begin
            c.illegal   = 1'b0;
            c.alu_op    = (op == OP_ADD) ? ALU_ADD : ALU_ADDU;
            c.reg_write = 1'b1;
            c.uses_rs   = 1'b1;
            c.uses_rt   = 1'b1;
         end
         OP_STORE: begin
            c.illegal     = 1'b0;
            c.alu_op      = ALU_ADD;
            c.alu_src_imm = 1'b1;
            c.mem_write   = 1'b1;
            c.uses_rs     = 1'b1;
         end
         OP_LOAD: begin
            c.illegal     = 1'b0;
            c.alu_op      = ALU_ADD;
            c.alu_src_imm = 1'b1;
            c.mem_read    = 1'b1;
            c.reg_write   = 1'b1;
            c.uses_rs     = 1'b1;
         end
         OP_LOADI: begin
            c.illegal     = 1'b0;
            c.alu_op      = ALU_PASSB;
            c.alu_src_imm = 1'b1;
            c.reg_write   = 1'b1;
         end
         OP_BEQ: begin
            c.illegal = 1'b0;
            c.alu_op  = ALU_SUB;
            c.branch  = 1'b1;
            c.uses_rs = 1'b1;
            c.uses_rt = 1'b1;
         end
         OP_SLT: begin
            c.illegal   = 1'b0;
            c.alu_op    = ALU_SLT;
            c.reg_write = 1'b1;
            c.uses_rs   = 1'b1;
            c.uses_rt   = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage_if
//  Description : Fetch-side and execute-side valid/ready channels of the
//                decode stage. The stage is the slave; its environment
//                (fetch plus downstream consumer) is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_decode_stage_if #(
   parameter int OP_W    = 5,
   parameter int REG_W   = 5,
   parameter int IMM_W   = 8,
   parameter int INSTR_W = 28,
   parameter int DATA_W  = 28,
   parameter int PC_W    = 16
);
   import instr_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_pc;

   logic               out_valid;
   logic               out_ready;
   logic [OP_W-1:0]    out_opcode;
   logic [REG_W-1:0]   out_rs;
   logic [REG_W-1:0]   out_rt;
   logic [REG_W-1:0]   out_rd;
   logic [DATA_W-1:0]  out_imm;
   logic [PC_W-1:0]    out_pc;
   logic [PC_W-1:0]    out_br_target;
   alu_op_e            out_alu_op;
   logic               out_alu_src_imm;
   logic               out_reg_write;
   logic               out_mem_read;
   logic               out_mem_write;
   logic               out_branch;
   logic               out_uses_rs;
   logic               out_uses_rt;
   logic               out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm,
             out_pc, out_br_target, out_alu_op, out_alu_src_imm, out_reg_write,
             out_mem_read, out_mem_write, out_branch, out_uses_rs, out_uses_rt,
             out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm,
             out_pc, out_br_target, out_alu_op, out_alu_src_imm, out_reg_write,
             out_mem_read, out_mem_write, out_branch, out_uses_rs, out_uses_rt,
             out_illegal
   );

endinterface
`default_nettype wire

// File: rtl/instr_decode_stage_comb.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_comb
//  Description : Purely combinational decode of one instruction word and its
//                pc into fields, extended immediate, branch target and
//                control signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_comb
   import instr_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int REG_W   = 5,
   parameter int IMM_W   = 8,
   parameter int INSTR_W = 28,
   parameter int DATA_W  = 28,
   parameter int PC_W    = 16
) (
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   output logic [OP_W-1:0]    o_opcode,
   output logic [REG_W-1:0]   o_rs,
   output logic [REG_W-1:0]   o_rt,
   output logic [REG_W-1:0]   o_rd,
   output logic [DATA_W-1:0]  o_imm,
   output logic [PC_W-1:0]    o_br_target,
   output ctrl_t              o_ctrl
);

   localparam int c_OP_LSB = field_lsb(FLD_OP, REG_W, IMM_W);
   localparam int c_RS_LSB = field_lsb(FLD_RS, REG_W, IMM_W);
   localparam int c_RT_LSB = field_lsb(FLD_RT, REG_W, IMM_W);
   localparam int c_RD_LSB = field_lsb(FLD_RD, REG_W, IMM_W);

   logic [OP_W-1:0]  w_opcode;
   logic [REG_W-1:0] w_rs_raw;
   logic [REG_W-1:0] w_rt_raw;
   logic [REG_W-1:0] w_rd_raw;
   logic [IMM_W-1:0] w_imm_raw;
   logic             w_is_store;
   logic             w_is_load;
   logic             w_is_loadi;
   logic             w_is_beq;

   assign w_opcode  = i_instr[c_OP_LSB +: OP_W];
   assign w_rs_raw  = i_instr[c_RS_LSB +: REG_W];
   assign w_rt_raw  = i_instr[c_RT_LSB +: REG_W];
   assign w_rd_raw  = i_instr[c_RD_LSB +: REG_W];
   assign w_imm_raw = i_instr[IMM_W-1:0];

   assign w_is_store = (w_opcode == OP_W'(OP_STORE));
   assign w_is_load  = (w_opcode == OP_W'(OP_LOAD));
   assign w_is_loadi = (w_opcode == OP_W'(OP_LOADI));
   assign w_is_beq   = (w_opcode == OP_W'(OP_BEQ));

   // Field outputs: register numbers the opcode does not use are forced to 0
   // so hazard logic never matches on stale encoding bits
   always_comb begin
      o_opcode = w_opcode;
      o_rs     = w_is_loadi ? '0 : w_rs_raw;
      o_rt     = (w_is_store || w_is_load || w_is_loadi) ? '0 : w_rt_raw;
      o_rd     = w_is_beq ? '0 : w_rd_raw;
      o_imm    = w_is_loadi ? DATA_W'(w_imm_raw) : DATA_W'($signed(w_imm_raw));
      // Branch offset is always signed, regardless of opcode
      o_br_target = i_pc + PC_W'($signed(w_imm_raw));
      o_ctrl      = decode_ctrl(32'(w_opcode));
   end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : Registered decode pipeline stage. Combinational decode feeds
//                a main output register backed by one skid entry so in_ready
//                can be registered while sustaining one instruction per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage
   import instr_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int REG_W   = 5,
   parameter int IMM_W   = 8,
   parameter int INSTR_W = 28,
   parameter int DATA_W  = 28,
   parameter int PC_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   instr_decode_stage_if.slave bus
);

   // Reject inconsistent geometry at elaboration time
   generate
      if (INSTR_W != OP_W + 3 * REG_W + IMM_W) begin : g_bad_instr_w
         $error("instr_decode_stage: INSTR_W must equal OP_W+3*REG_W+IMM_W");
      end
      if (DATA_W < IMM_W) begin : g_bad_data_w
         $error("instr_decode_stage: DATA_W must be >= IMM_W");
      end
   endgenerate

   typedef struct packed {
      logic [OP_W-1:0]   opcode;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] imm;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   br_target;
      ctrl_t             ctrl;
   } bundle_t;

   logic [OP_W-1:0]   w_opcode;
   logic [REG_W-1:0]  w_rs;
   logic [REG_W-1:0]  w_rt;
   logic [REG_W-1:0]  w_rd;
   logic [DATA_W-1:0] w_imm;
   logic [PC_W-1:0]   w_br_target;
   ctrl_t             w_ctrl;
   bundle_t           w_dec;
   logic              w_in_fire;
   logic              w_main_free;

   bundle_t r_main;
   bundle_t r_skid;
   logic    r_main_valid;
   logic    r_skid_valid;
   logic    r_in_ready;

   instr_decode_comb #(
      .OP_W    (OP_W),
      .REG_W   (REG_W),
      .IMM_W   (IMM_W),
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W),
      .PC_W    (PC_W)
   ) u_decode (
      .i_instr     (bus.in_instr),
      .i_pc        (bus.in_pc),
      .o_opcode    (w_opcode),
      .o_rs        (w_rs),
      .o_rt        (w_rt),
      .o_rd        (w_rd),
      .o_imm       (w_imm),
      .o_br_target (w_br_target),
      .o_ctrl      (w_ctrl)
   );

   assign w_dec = '{opcode:    w_opcode,
                    rs:        w_rs,
                    rt:        w_rt,
                    rd:        w_rd,
                    imm:       w_imm,
                    pc:        bus.in_pc,
                    br_target: w_br_target,
                    ctrl:      w_ctrl};

   assign w_in_fire   = bus.in_valid && r_in_ready;
   // Main register can take new content when empty or being consumed this cycle
   assign w_main_free = !r_main_valid || bus.out_ready;

   // Main/skid handshake state; in_ready tracks the next-cycle skid emptiness
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b0;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_main_free) begin
         // in_ready is low whenever skid is full, so skid and input never compete
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_main_valid <= w_in_fire;
            if (w_in_fire) begin
               r_main <= w_dec;
            end
         end
         r_in_ready <= 1'b1;
      end else if (w_in_fire) begin
         // Main is stalled: park the new bundle and stop accepting
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
         r_in_ready   <= 1'b0;
      end
   end

   assign bus.in_ready        = r_in_ready;
   assign bus.out_valid       = r_main_valid;
   assign bus.out_opcode      = r_main.opcode;
   assign bus.out_rs          = r_main.rs;
   assign bus.out_rt          = r_main.rt;
   assign bus.out_rd          = r_main.rd;
   assign bus.out_imm         = r_main.imm;
   assign bus.out_pc          = r_main.pc;
   assign bus.out_br_target   = r_main.br_target;
   assign bus.out_alu_op      = r_main.ctrl.alu_op;
   assign bus.out_alu_src_imm = r_main.ctrl.alu_src_imm;
   assign bus.out_reg_write   = r_main.ctrl.reg_write;
   assign bus.out_mem_read    = r_main.ctrl.mem_read;
   assign bus.out_mem_write   = r_main.ctrl.mem_write;
   assign bus.out_branch      = r_main.ctrl.branch;
   assign bus.out_uses_rs     = r_main.ctrl.uses_rs;
   assign bus.out_uses_rt     = r_main.ctrl.uses_rt;
   assign bus.out_illegal     = r_main.ctrl.illegal;

endmodule
`default_nettype wire
